// File: rtl/wb_result_select.sv
// wb_result_select
//   Writeback result selector for the RISC-V datapath. Each accepted input
//   picks one of NUM_SRC result sources; valid selections are queued with
//   their destination tag in a 2-entry skid FIFO and presented on p_o /
//   p_o_tag with flag as the valid. p_o holds the last popped value when the
//   FIFO is empty. A wrapping retire counter counts pops, and bad_sel is a
//   sticky flag for out-of-range selections.
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready = FIFO not full)
//   src_sel             0 = bubble, k in 1..NUM_SRC selects source k-1
//   src_data            packed sources, source k at [k*DATA_W +: DATA_W]
//   in_tag              destination tag of the offered result
//   p_o/p_o_tag/flag    FIFO head result, tag and valid
//   out_ready           downstream consumes the head when flag=1
//   retire_cnt          number of pops, modulo 2**CNT_W
//   bad_sel             sticky: src_sel > NUM_SRC accepted since reset
module wb_result_select #(
  parameter int DATA_W  = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 4,
  parameter int TAG_W   = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          src_sel,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [TAG_W-1:0]          in_tag,
  output logic [DATA_W-1:0]         p_o,
  output logic [TAG_W-1:0]          p_o_tag,
  output logic                      flag,
  input  logic                      out_ready,
  output logic [CNT_W-1:0]          retire_cnt,
  output logic                      bad_sel
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_SRC);

  logic [DATA_W-1:0] mem_data [2];
  logic [TAG_W-1:0]  mem_tag  [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;

  logic              accept;
  logic              sel_ok;
  logic              push;
  logic              pop;
  logic              rd_next;
  logic [1:0]        count_next;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] head_data_next;
  logic [TAG_W-1:0]  head_tag_next;

  assign in_ready = (count != 2'd2);
  assign flag     = (count != 2'd0);
  assign accept   = in_valid & in_ready;
  assign sel_ok   = (src_sel != '0) && (src_sel <= MAX_SEL);
  assign push     = accept & sel_ok;
  assign pop      = flag & out_ready;
  assign rd_next  = rd_ptr ^ pop;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (src_sel == SEL_W'(k + 1))
        sel_data = src_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Head after this edge: if the slot that becomes the head is being written
  // right now, take the incoming result directly (empty push, or push+pop in ONE).
  always_comb begin
    if (push && (wr_ptr == rd_next)) begin
      head_data_next = sel_data;
      head_tag_next  = in_tag;
    end else begin
      head_data_next = mem_data[rd_next];
      head_tag_next  = mem_tag[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= sel_data;
      mem_tag[wr_ptr]  <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      p_o        <= '0;
      p_o_tag    <= '0;
      retire_cnt <= '0;
      bad_sel    <= 1'b0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_next;
      if (push)
        wr_ptr <= ~wr_ptr;
      if (pop)
        retire_cnt <= retire_cnt + 1'b1;
      // Going empty leaves p_o holding the value just popped.
      if (count_next != 2'd0) begin
        p_o     <= head_data_next;
        p_o_tag <= head_tag_next;
      end
      if (accept && (src_sel > MAX_SEL))
        bad_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_result_select.sv
module tb_wb_result_select;
  localparam int DATA_W  = 32;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 4;
  localparam int TAG_W   = 5;
  localparam int CNT_W   = 8;   // narrow counter so the wrap is reachable quickly

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [SEL_W-1:0]          src_sel = '0;
  logic [NUM_SRC*DATA_W-1:0] src_data = '0;
  logic [TAG_W-1:0]          in_tag = '0;
  logic [DATA_W-1:0]         p_o;
  logic [TAG_W-1:0]          p_o_tag;
  logic                      flag;
  logic                      out_ready = 1'b0;
  logic [CNT_W-1:0]          retire_cnt;
  logic                      bad_sel;

  wb_result_select #(
    .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .src_sel(src_sel), .src_data(src_data), .in_tag(in_tag),
    .p_o(p_o), .p_o_tag(p_o_tag), .flag(flag), .out_ready(out_ready),
    .retire_cnt(retire_cnt), .bad_sel(bad_sel)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TAG_W-1:0]  t;
  } entry_t;

  entry_t            q[$];
  logic [DATA_W-1:0] last_d = '0;
  logic [TAG_W-1:0]  last_t = '0;
  logic [CNT_W-1:0]  ret_exp = '0;
  logic              bad_exp = 1'b0;
  logic              ready_exp = 1'b1;
  bit                started = 1'b0;
  int                total = 0;
  int                bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares the outputs against the reference queue, then retires
  // the head if the downstream takes it at the coming edge.
  always @(negedge clk) begin
    if (started && !reset) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("flag", flag, q.size() > 0);
      chk("p_o", p_o, (q.size() > 0) ? q[0].d : last_d);
      chk("p_o_tag", p_o_tag, (q.size() > 0) ? q[0].t : last_t);
      chk("retire_cnt", retire_cnt, ret_exp);
      chk("bad_sel", bad_sel, bad_exp);
      ready_exp = (q.size() < 2);
      if (q.size() > 0 && out_ready) begin
        last_d = q[0].d;
        last_t = q[0].t;
        void'(q.pop_front());
        ret_exp = ret_exp + 1'b1;
      end
    end
  end

  // Driver: applies one cycle of stimulus and records what the edge accepts.
  task automatic step(input bit v, input int sel, input logic [DATA_W-1:0] d,
                      input logic [TAG_W-1:0] t, input bit ordy, input bit rst);
    in_valid  = v;
    src_sel   = SEL_W'(sel);
    for (int k = 0; k < NUM_SRC; k++)
      src_data[k*DATA_W +: DATA_W] = $urandom;
    if (sel >= 1 && sel <= NUM_SRC)
      src_data[(sel-1)*DATA_W +: DATA_W] = d;
    in_tag    = t;
    out_ready = ordy;
    reset     = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      last_d = '0; last_t = '0; ret_exp = '0; bad_exp = 1'b0; ready_exp = 1'b1;
    end else if (v && ready_exp) begin
      if (sel >= 1 && sel <= NUM_SRC) begin
        entry_t e;
        e.d = d;
        e.t = t;
        q.push_back(e);
      end else if (sel > NUM_SRC) begin
        bad_exp = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, '0, '0, ordy, 0);
  endtask

  initial begin
    #1;
    step(0, 0, '0, '0, 0, 1);
    step(0, 0, '0, '0, 0, 1);
    started = 1'b1;
    reset = 1'b0;
    idle(0); idle(0);

    // single result, consumed immediately
    step(1, 1, 32'h0000_00AA, 5'd3, 1, 0);
    idle(1); idle(1);

    // two results queued while stalled, then drained in order
    step(1, 2, 32'h0000_1111, 5'd1, 0, 0);
    step(1, 3, 32'h0000_2222, 5'd2, 0, 0);
    idle(0); idle(0);
    idle(1); idle(1); idle(1);

    // steady stream: push + pop every cycle
    for (int i = 0; i < 20; i++)
      step(1, $urandom_range(1, NUM_SRC), $urandom, 5'($urandom), 1, 0);
    idle(1); idle(1);

    // bubble, then out-of-range select
    step(1, 0, 32'hDEAD_BEEF, 5'd7, 1, 0);
    idle(1);
    step(1, NUM_SRC + 1, 32'hDEAD_BEEF, 5'd7, 1, 0);
    idle(1); idle(1);
    step(0, 0, '0, '0, 0, 1);
    idle(1);

    // FULL, then reset discards both entries
    step(1, 4, 32'h3333_3333, 5'd9, 0, 0);
    step(1, 1, 32'h4444_4444, 5'd10, 0, 0);
    idle(0);
    step(0, 0, '0, '0, 0, 1);
    idle(1); idle(1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int sel;
      sel = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (1 << SEL_W) - 1)
                                        : $urandom_range(1, NUM_SRC);
      step(($urandom_range(0, 3) != 0), sel, $urandom, 5'($urandom),
           ($urandom_range(0, 2) != 0), 0);
    end
    for (int i = 0; i < 4; i++) idle(1);

    // retire counter wrap: exactly 2**CNT_W pops after reset
    step(0, 0, '0, '0, 0, 1);
    for (int i = 0; i < (1 << CNT_W); i++)
      step(1, $urandom_range(1, NUM_SRC), $urandom, 5'($urandom), 1, 0);
    idle(1);
    @(negedge clk);
    chk("retire_wrap", retire_cnt, '0);
    chk("wrap_flag", flag, 1'b0);
    #1;
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1);
  end
endmodule
